pmem_arbiter: RTL and testbench
===============================

// Module: pmem_arbiter
// PURPOSE
//  Shares the single physical-memory port between the instruction cache and the data cache.
//  Grants one cache-line transaction at a time, with round-robin priority on contention.
//  Latches the winning request and drives the pmem_* interface until pmem_resp.
//  Returns rdata/resp to the granted cache. Sits between the split L1 caches and physical memory.
// PARAMETERS
//  ADDR_WIDTH  32   byte address width of pmem_address
//  LINE_WIDTH  256  cache-line width (pmem data bus)
// PORTS
//  clk             in   1           system clock; all state updates on rising edge
//  rst_n           in   1           synchronous active-low reset
//  i_pmem_read     in   1           I-cache line-fill request (held until i_pmem_resp)
//  i_pmem_address  in   ADDR_WIDTH  I-cache line address
//  i_pmem_rdata    out  LINE_WIDTH  line data to I-cache
//  i_pmem_resp     out  1           1-cycle completion pulse to I-cache
//  d_pmem_read     in   1           D-cache line-fill request (held until d_pmem_resp)
//  d_pmem_write    in   1           D-cache writeback request (held until d_pmem_resp)
//  d_pmem_address  in   ADDR_WIDTH  D-cache line address
//  d_pmem_wdata    in   LINE_WIDTH  writeback line
//  d_pmem_rdata    out  LINE_WIDTH  line data to D-cache
//  d_pmem_resp     out  1           1-cycle completion pulse to D-cache
//  pmem_read       out  1           physical memory read strobe
//  pmem_write      out  1           physical memory write strobe
//  pmem_address    out  ADDR_WIDTH  physical memory address
//  pmem_wdata      out  LINE_WIDTH  physical memory write data
//  pmem_rdata      in   LINE_WIDTH  physical memory read data
//  pmem_resp       in   1           physical memory completion
// BEHAVIOUR
//  - States: IDLE, SERVE_I, SERVE_D. Reset (rst_n=0 at edge) -> IDLE, last_grant=D, latches cleared.
//  - Reset values: pmem_read=pmem_write=0, i/d_pmem_resp=0, pmem_address=0, pmem_wdata=0.
//  - IDLE: only I requests -> SERVE_I. Only D requests (read|write) -> SERVE_D.
//    Both request -> grant the one != last_grant. None -> stay.
//  - On the grant edge, latch op (rd/wr), address and wdata into a txn register.
//    pmem_* are driven only from that register; requester changes mid-transaction are ignored.
//  - SERVE_x: pmem_read/pmem_write held high (from latched op) until pmem_resp=1.
//  - On pmem_resp: x_pmem_resp=1 combinationally in the same cycle. x_pmem_rdata=pmem_rdata.
//    Next state is IDLE and last_grant<=x. Deassert pmem_read/write from the following cycle.
//  - Latency: request rises in cycle N -> pmem strobe in N+1. Resp passthrough is 0 cycles.
//    Minimum one IDLE bubble between consecutive transactions.
//  - The non-granted x_pmem_resp is always 0. rdata outputs may show pmem_rdata when resp=0
//    (don't-care).
//  - d_pmem_read & d_pmem_write both 1: write wins. Flagged by an assertion (illegal).
//  - pmem_resp while in IDLE: ignored, no resp forwarded.
//  - Request dropped mid-transaction: transaction still completes and the resp pulse is still issued.
//  - Reset mid-transaction: strobes low after the reset edge. State IDLE. A late pmem_resp is ignored.
//  - Only one pmem strobe is ever high. pmem_address/wdata are stable while a strobe is high.
// STRUCTURE
//  - Package pmem_arb_types: arb_state_t enum {IDLE, SERVE_I, SERVE_D}, requester_t {REQ_I, REQ_D},
//    txn_t struct {logic wr; logic [ADDR_WIDTH-1:0] addr; logic [LINE_WIDTH-1:0] wdata}.
//  - Sub-module pmem_arbiter_ctrl: FSM plus last_grant, outputs grant/latch_en/serving.
//    Top level holds the txn register and the response demux.
// TESTING
//  - Lone I read 0x0000_1000, pmem_resp after 3 cycles -> pmem_read=1 at N+1, pmem_address=0x1000.
//    i_pmem_resp pulses 1 cycle with data. d_pmem_resp stays 0.
//  - I read and D write 0x0000_2000 both at N after reset -> I served first (last_grant=D).
//    One IDLE cycle, then pmem_write=1 with address 0x2000 and wdata forwarded.
//  - Back-to-back contention for 4 transactions -> grant order alternates I,D,I,D. No overlap of strobes.
//  - D drops d_pmem_read after the grant and changes address to 0x3000 -> pmem_address keeps the
//    latched value. d_pmem_resp still pulses.
//  - rst_n=0 while SERVE_D with pmem_write high -> pmem_write=0 after the edge, state IDLE.
//    pmem_resp next cycle yields no resp to either cache.
//  - pmem_resp injected in IDLE -> i/d_pmem_resp stay 0. d read+write both high -> assertion fires, write issued.

Source files
------------

// File: rtl/pmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pmem_arb_types (package)
//  Description : Shared types and widths for the physical-memory arbiter.
//                arb_state_t  - controller FSM encoding
//                requester_t  - which L1 cache owns the memory port
//                txn_t        - latched transaction (op, address, write line)
//  Revision    : 1.0 - initial release
// ============================================================================
package pmem_arb_types;

  localparam int ARB_ADDR_WIDTH = 32;   // byte address width of pmem_address
  localparam int ARB_LINE_WIDTH = 256;  // cache-line width of the pmem data bus

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

  typedef struct packed {
    logic                      wr;
    logic [ARB_ADDR_WIDTH-1:0] addr;
    logic [ARB_LINE_WIDTH-1:0] wdata;
  } txn_t;

endpackage : pmem_arb_types
`default_nettype wire

// File: rtl/pmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : pmem_arbiter_if
//  Description : Line-transaction bus between a cache and physical memory.
//  Signals     : read, write      request strobes (held until resp)
//                address, wdata   line address and writeback line
//                rdata, resp      returned line and 1-cycle completion
//  Modports    : master   - side that issues requests (cache / arbiter->pmem)
//                slave    - side that answers requests
//                rd_slave - answering side of a read-only requester (I-cache)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pmem_arbiter_if
  import pmem_arb_types::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int LINE_WIDTH = ARB_LINE_WIDTH
);

  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] address;
  logic [LINE_WIDTH-1:0] wdata;
  logic [LINE_WIDTH-1:0] rdata;
  logic                  resp;

  modport master (
    output read, write, address, wdata,
    input  rdata, resp
  );

  modport slave (
    input  read, write, address, wdata,
    output rdata, resp
  );

  modport rd_slave (
    input  read, address,
    output rdata, resp
  );

endinterface : pmem_arbiter_if
`default_nettype wire

// File: rtl/pmem_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pmem_arbiter_ctrl
//  Description : Arbitration FSM. Picks one requester per transaction with
//                round-robin priority on contention, holds the grant until
//                physical memory responds, then returns to IDLE for at least
//                one cycle.
//  Ports       : clk, rst_n   clock, synchronous active-low reset
//                i_req        I-cache request (read)
//                d_req        D-cache request (read or write)
//                pmem_resp    physical memory completion
//                grant        requester selected (IDLE) / being served
//                latch_en     capture the granted request this edge
//                serving      a transaction is in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module pmem_arbiter_ctrl
  import pmem_arb_types::*;
(
  input  wire         clk,
  input  wire         rst_n,
  input  wire         i_req,
  input  wire         d_req,
  input  wire         pmem_resp,
  output requester_t  grant,
  output logic        latch_en,
  output logic        serving
);

  arb_state_t state;
  arb_state_t next_state;
  requester_t last_grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= REQ_D;   // I-cache wins the first contention after reset
    end else begin
      state <= next_state;
      if (serving && pmem_resp) begin
        last_grant <= grant;
      end
    end
  end

  always_comb begin
    next_state = state;
    grant      = REQ_I;
    latch_en   = 1'b0;
    serving    = 1'b0;

    unique case (state)
      IDLE: begin
        // On contention the requester that was not served last goes first.
        if (i_req && d_req) begin
          grant = (last_grant == REQ_D) ? REQ_I : REQ_D;
        end else if (d_req) begin
          grant = REQ_D;
        end else begin
          grant = REQ_I;
        end
        if (i_req || d_req) begin
          latch_en   = 1'b1;
          next_state = (grant == REQ_I) ? SERVE_I : SERVE_D;
        end
      end
      SERVE_I: begin
        grant   = REQ_I;
        serving = 1'b1;
        if (pmem_resp) begin
          next_state = IDLE;
        end
      end
      SERVE_D: begin
        grant   = REQ_D;
        serving = 1'b1;
        if (pmem_resp) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule : pmem_arbiter_ctrl
`default_nettype wire

// File: rtl/pmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pmem_arbiter
//  Description : Shares the single physical-memory port between the I-cache
//                and the D-cache, one cache-line transaction at a time.
//                The granted request is captured into a transaction register
//                and the memory port is driven only from that register, so
//                requester changes during a transaction have no effect.
//  Ports       : clk, rst_n   clock, synchronous active-low reset
//                i_pmem       I-cache port (read-only requester)
//                d_pmem       D-cache port (read / writeback requester)
//                pmem         physical memory port
//  Parameters  : CHECK_ILLEGAL  enable the read+write-together D-cache check
//  Revision    : 1.0 - initial release
// ============================================================================
module pmem_arbiter
  import pmem_arb_types::*;
#(
  parameter bit CHECK_ILLEGAL = 1'b1
)(
  input  wire              clk,
  input  wire              rst_n,
  pmem_arbiter_if.rd_slave i_pmem,
  pmem_arbiter_if.slave    d_pmem,
  pmem_arbiter_if.master   pmem
);

  requester_t grant;
  logic       latch_en;
  logic       serving;
  logic       d_req;
  logic       illegal_dual_op;
  txn_t       txn;

  assign d_req           = d_pmem.read | d_pmem.write;
  assign illegal_dual_op = d_pmem.read & d_pmem.write;

  pmem_arbiter_ctrl u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_pmem.read),
    .d_req     (d_req),
    .pmem_resp (pmem.resp),
    .grant     (grant),
    .latch_en  (latch_en),
    .serving   (serving)
  );

  // A D-cache asserting both strobes is treated as a writeback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txn <= '0;
    end else if (latch_en) begin
      if (grant == REQ_I) begin
        txn.wr    <= 1'b0;
        txn.addr  <= i_pmem.address;
        txn.wdata <= '0;
      end else begin
        txn.wr    <= d_pmem.write;
        txn.addr  <= d_pmem.address;
        txn.wdata <= d_pmem.wdata;
      end
    end
  end

  assign pmem.read    = serving & ~txn.wr;
  assign pmem.write   = serving &  txn.wr;
  assign pmem.address = txn.addr;
  assign pmem.wdata   = txn.wdata;

  // Completion is forwarded in the same cycle only to the served cache;
  // a response arriving while idle reaches nobody.
  assign i_pmem.resp  = serving & (grant == REQ_I) & pmem.resp;
  assign d_pmem.resp  = serving & (grant == REQ_D) & pmem.resp;
  assign i_pmem.rdata = pmem.rdata;
  assign d_pmem.rdata = pmem.rdata;

  generate
    if (CHECK_ILLEGAL) begin : g_illegal_chk
      a_no_dual_op : assert property (@(posedge clk) disable iff (!rst_n)
                                      !illegal_dual_op);
    end
  endgenerate

endmodule : pmem_arbiter
`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pmem_arbiter
//  Description : Directed self-checking bench for pmem_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pmem_arbiter;
  import pmem_arb_types::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pmem_arbiter_if i_bus ();
  pmem_arbiter_if d_bus ();
  pmem_arbiter_if m_bus ();

  pmem_arbiter #(.CHECK_ILLEGAL(1'b0)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pmem (i_bus),
    .d_pmem (d_bus),
    .pmem   (m_bus)
  );

  localparam logic [255:0] R1 = {8{32'hA1A1_0001}};
  localparam logic [255:0] R2 = {8{32'hB2B2_0002}};
  localparam logic [255:0] R4 = {8{32'hC4C4_0004}};
  localparam logic [255:0] W2 = {8{32'hD00D_2000}};
  localparam logic [255:0] W5 = {8{32'hE55E_2800}};
  localparam logic [255:0] W7 = {8{32'hF77F_3400}};

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_addr(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_line(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    i_bus.read    = 1'b0;
    i_bus.write   = 1'b0;
    i_bus.address = '0;
    i_bus.wdata   = '0;
    d_bus.read    = 1'b0;
    d_bus.write   = 1'b0;
    d_bus.address = '0;
    d_bus.wdata   = '0;
    m_bus.rdata   = '0;
    m_bus.resp    = 1'b0;
    step();
    step();

    // ---- reset state
    settle();
    chk_bit ("rst_read",  m_bus.read,  1'b0);
    chk_bit ("rst_write", m_bus.write, 1'b0);
    chk_addr("rst_addr",  m_bus.address, 32'h0);
    chk_line("rst_wdata", m_bus.wdata, 256'h0);
    chk_bit ("rst_iresp", i_bus.resp, 1'b0);
    chk_bit ("rst_dresp", d_bus.resp, 1'b0);
    rst_n = 1'b1;
    step();

    // ---- lone I read, memory answers in the third serving cycle
    i_bus.read    = 1'b1;
    i_bus.address = 32'h0000_1000;
    settle();
    chk_bit ("t1_no_strobe_N", m_bus.read, 1'b0);
    step();
    chk_bit ("t1_read_N1",  m_bus.read, 1'b1);
    chk_bit ("t1_write_N1", m_bus.write, 1'b0);
    chk_addr("t1_addr_N1",  m_bus.address, 32'h0000_1000);
    step();
    chk_bit ("t1_read_N2",  m_bus.read, 1'b1);
    chk_bit ("t1_iresp_N2", i_bus.resp, 1'b0);
    step();
    m_bus.resp  = 1'b1;
    m_bus.rdata = R1;
    settle();
    chk_bit ("t1_iresp",  i_bus.resp, 1'b1);
    chk_line("t1_irdata", i_bus.rdata, R1);
    chk_bit ("t1_dresp",  d_bus.resp, 1'b0);
    step();
    m_bus.resp = 1'b0;
    i_bus.read = 1'b0;
    settle();
    chk_bit ("t1_read_off", m_bus.read, 1'b0);
    chk_bit ("t1_iresp_off", i_bus.resp, 1'b0);

    // ---- contention right after reset: I first, one bubble, then D write
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    i_bus.read    = 1'b1;
    i_bus.address = 32'h0000_1040;
    d_bus.write   = 1'b1;
    d_bus.address = 32'h0000_2000;
    d_bus.wdata   = W2;
    step();
    chk_bit ("t2_i_read",  m_bus.read, 1'b1);
    chk_bit ("t2_i_write", m_bus.write, 1'b0);
    chk_addr("t2_i_addr",  m_bus.address, 32'h0000_1040);
    m_bus.resp  = 1'b1;
    m_bus.rdata = R2;
    settle();
    chk_bit ("t2_iresp", i_bus.resp, 1'b1);
    chk_bit ("t2_dresp_idle", d_bus.resp, 1'b0);
    step();
    m_bus.resp = 1'b0;
    i_bus.read = 1'b0;
    settle();
    chk_bit ("t2_bubble_read",  m_bus.read, 1'b0);
    chk_bit ("t2_bubble_write", m_bus.write, 1'b0);
    step();
    chk_bit ("t2_d_write", m_bus.write, 1'b1);
    chk_bit ("t2_d_read",  m_bus.read, 1'b0);
    chk_addr("t2_d_addr",  m_bus.address, 32'h0000_2000);
    chk_line("t2_d_wdata", m_bus.wdata, W2);
    m_bus.resp = 1'b1;
    settle();
    chk_bit ("t2_dresp", d_bus.resp, 1'b1);
    chk_bit ("t2_iresp_off", i_bus.resp, 1'b0);
    step();
    m_bus.resp  = 1'b0;
    d_bus.write = 1'b0;
    settle();
    chk_bit ("t2_write_off", m_bus.write, 1'b0);

    // ---- sustained contention: grants alternate I, D, I, D (last was D)
    i_bus.read    = 1'b1;
    i_bus.address = 32'h0000_1100;
    d_bus.read    = 1'b1;
    d_bus.address = 32'h0000_2200;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_bit ("t3_one_strobe", m_bus.read & m_bus.write, 1'b0);
      chk_bit ("t3_read", m_bus.read, 1'b1);
      chk_addr("t3_addr", m_bus.address, (k % 2 == 0) ? 32'h0000_1100 : 32'h0000_2200);
      m_bus.resp = 1'b1;
      settle();
      chk_bit ("t3_iresp", i_bus.resp, (k % 2 == 0));
      chk_bit ("t3_dresp", d_bus.resp, (k % 2 == 1));
      step();
      m_bus.resp = 1'b0;
      settle();
      chk_bit ("t3_bubble", m_bus.read | m_bus.write, 1'b0);
    end
    i_bus.read = 1'b0;
    d_bus.read = 1'b0;
    step();

    // ---- D drops its request and changes address mid-transaction
    d_bus.read    = 1'b1;
    d_bus.address = 32'h0000_2400;
    step();
    chk_addr("t4_addr_grant", m_bus.address, 32'h0000_2400);
    d_bus.read    = 1'b0;
    d_bus.address = 32'h0000_3000;
    settle();
    chk_bit ("t4_read_held", m_bus.read, 1'b1);
    chk_addr("t4_addr_held", m_bus.address, 32'h0000_2400);
    step();
    chk_addr("t4_addr_held2", m_bus.address, 32'h0000_2400);
    m_bus.resp  = 1'b1;
    m_bus.rdata = R4;
    settle();
    chk_bit ("t4_dresp",  d_bus.resp, 1'b1);
    chk_line("t4_drdata", d_bus.rdata, R4);
    chk_bit ("t4_iresp",  i_bus.resp, 1'b0);
    step();
    m_bus.resp = 1'b0;
    settle();
    chk_bit ("t4_read_off", m_bus.read, 1'b0);

    // ---- reset while serving a D write, then a late response
    d_bus.write   = 1'b1;
    d_bus.address = 32'h0000_2800;
    d_bus.wdata   = W5;
    step();
    chk_bit ("t5_write_on", m_bus.write, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n       = 1'b1;
    d_bus.write = 1'b0;
    settle();
    chk_bit ("t5_write_after_rst", m_bus.write, 1'b0);
    chk_bit ("t5_state_idle", dut.u_ctrl.state === IDLE, 1'b1);
    chk_addr("t5_addr_cleared", m_bus.address, 32'h0);
    step();
    m_bus.resp = 1'b1;
    settle();
    chk_bit ("t5_late_iresp", i_bus.resp, 1'b0);
    chk_bit ("t5_late_dresp", d_bus.resp, 1'b0);

    // ---- response while idle for a second cycle
    step();
    settle();
    chk_bit ("t6_idle_iresp", i_bus.resp, 1'b0);
    chk_bit ("t6_idle_dresp", d_bus.resp, 1'b0);
    chk_bit ("t6_idle_strobe", m_bus.read | m_bus.write, 1'b0);
    m_bus.resp = 1'b0;
    step();

    // ---- illegal read+write from D: flagged, write wins
    d_bus.read    = 1'b1;
    d_bus.write   = 1'b1;
    d_bus.address = 32'h0000_3400;
    d_bus.wdata   = W7;
    settle();
    chk_bit ("t7_flag", dut.illegal_dual_op, 1'b1);
    step();
    chk_bit ("t7_write", m_bus.write, 1'b1);
    chk_bit ("t7_read",  m_bus.read, 1'b0);
    chk_addr("t7_addr",  m_bus.address, 32'h0000_3400);
    chk_line("t7_wdata", m_bus.wdata, W7);
    d_bus.read  = 1'b0;
    d_bus.write = 1'b0;
    m_bus.resp  = 1'b1;
    settle();
    chk_bit ("t7_dresp", d_bus.resp, 1'b1);
    step();
    m_bus.resp = 1'b0;
    settle();
    chk_bit ("t7_write_off", m_bus.write, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_pmem_arbiter
`default_nettype wire
